// File: rtl/alu4bit_pkg.sv
// alu4bit_pkg: shared definitions for the 4-bit registered ALU.
//   opcode_e  : 3-bit operation code, encoded {M,S1,S0}
//   RES_W     : result width (4)
//   is_arith  : true for the four arithmetic operations (M = 0)
// Optional feature macro used by the design: ALU4BIT_FLAGS_EN.
package alu4bit_pkg;

  localparam int RES_W = 4;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_INC = 3'b010,
    OP_DEC = 3'b011,
    OP_AND = 3'b100,
    OP_OR  = 3'b101,
    OP_XOR = 3'b110,
    OP_NOT = 3'b111
  } opcode_e;

  // The mode bit M is the opcode MSB; M = 0 selects the arithmetic group.
  function automatic logic is_arith(input opcode_e op);
    return ~op[2];
  endfunction

endpackage

// File: rtl/alu4bit_if.sv
// alu4bit_if: operand/result bundle between the ALU register stage and the
// combinational core.
//   a, b    : operands
//   op      : opcode {M,S1,S0}
//   result  : 4-bit result
//   carry   : carry-out / no-borrow (0 in logic mode)
//   zero/ovf: status flags, present only when ALU4BIT_FLAGS_EN is defined
// Handshake: none. Operands and opcode are valid every cycle and the result
// is a pure function of them; there is no valid/ready pair.
// Modports: master drives operands and reads results, slave (the core)
// reads operands and drives results.
interface alu4bit_if;
  import alu4bit_pkg::*;

  logic [RES_W-1:0] a;
  logic [RES_W-1:0] b;
  opcode_e          op;
  logic [RES_W-1:0] result;
  logic             carry;
`ifdef ALU4BIT_FLAGS_EN
  logic             zero;
  logic             ovf;

  modport master (output a, b, op, input result, carry, zero, ovf);
  modport slave  (input a, b, op, output result, carry, zero, ovf);
`else
  modport master (output a, b, op, input result, carry);
  modport slave  (input a, b, op, output result, carry);
`endif

endinterface

// File: rtl/alu4bit_core.sv
// alu4bit_core: purely combinational 4-bit ALU datapath.
// Ports:
//   bus (alu4bit_if.slave): reads a, b, op; drives result, carry and, when
//   ALU4BIT_FLAGS_EN is defined, zero and ovf.
// All four arithmetic operations share one 5-bit adder: a + addend + cin.
module alu4bit_core
  import alu4bit_pkg::*;
(
  alu4bit_if.slave bus
);

  logic [RES_W-1:0] addend;
  logic             cin;
  logic [RES_W:0]   sum;

  // Map each arithmetic op onto the shared adder:
  //   SUB = a + ~b + 1, INC = a + 0001, DEC = a + 1111.
  always_comb begin
    addend = '0;
    cin    = 1'b0;
    case (bus.op)
      OP_ADD:  addend = bus.b;
      OP_SUB:  begin
        addend = ~bus.b;
        cin    = 1'b1;
      end
      OP_INC:  addend = 4'b0001;
      OP_DEC:  addend = 4'b1111;
      default: addend = '0;
    endcase
    sum = {1'b0, bus.a} + {1'b0, addend} + {{RES_W{1'b0}}, cin};
  end

  always_comb begin
    bus.result = sum[RES_W-1:0];
    bus.carry  = 1'b0;
    case (bus.op)
      OP_AND:  bus.result = bus.a & bus.b;
      OP_OR:   bus.result = bus.a | bus.b;
      OP_XOR:  bus.result = bus.a ^ bus.b;
      OP_NOT:  bus.result = ~bus.a;
      default: begin
        bus.result = sum[RES_W-1:0];
        bus.carry  = sum[RES_W];
      end
    endcase
  end

`ifdef ALU4BIT_FLAGS_EN
  // Signed overflow: both adder inputs share a sign and the result sign
  // differs. Using the actual addend (~b for SUB) covers all four ops.
  always_comb begin
    bus.zero = (bus.result == '0);
    bus.ovf  = is_arith(bus.op)
             & (bus.a[RES_W-1] == addend[RES_W-1])
             & (sum[RES_W-1] != bus.a[RES_W-1]);
  end
`endif

endmodule

// File: rtl/alu4bit.sv
// alu4bit: 4-bit registered ALU for the toy processor datapath.
// Ports:
//   clk          rising-edge clock
//   rst          synchronous reset, active-high (clears all outputs)
//   A, B         4-bit operands
//   S0, S1, M    opcode select {M,S1,S0}; M = 1 selects logic mode
//   CiOut        carry-out (ADD/INC) or no-borrow (SUB/DEC); 0 in logic mode
//   F3..F0       registered result bits, F3 = MSB
//   Zero, Ovf    registered status flags, only when ALU4BIT_FLAGS_EN is defined
// One clock of latency: inputs sampled at a rising edge appear on the
// outputs right after that edge and hold until the next edge.
module alu4bit
  import alu4bit_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       S0,
  input  logic       S1,
  input  logic       M,
  output logic       CiOut,
  output logic       F3,
  output logic       F2,
  output logic       F1,
  output logic       F0
`ifdef ALU4BIT_FLAGS_EN
  ,
  output logic       Zero,
  output logic       Ovf
`endif
);

  alu4bit_if core_bus ();

  assign core_bus.a  = A;
  assign core_bus.b  = B;
  assign core_bus.op = opcode_e'({M, S1, S0});

  alu4bit_core u_core (
    .bus (core_bus)
  );

  logic [RES_W-1:0] result_d, result_q;
  logic             carry_d,  carry_q;

  always_comb begin
    result_d = core_bus.result;
    carry_d  = core_bus.carry;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      result_q <= '0;
      carry_q  <= 1'b0;
    end else begin
      result_q <= result_d;
      carry_q  <= carry_d;
    end
  end

  assign F3    = result_q[3];
  assign F2    = result_q[2];
  assign F1    = result_q[1];
  assign F0    = result_q[0];
  assign CiOut = carry_q;

`ifdef ALU4BIT_FLAGS_EN
  logic zero_d, zero_q;
  logic ovf_d,  ovf_q;

  always_comb begin
    zero_d = core_bus.zero;
    ovf_d  = core_bus.ovf;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      zero_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      zero_q <= zero_d;
      ovf_q  <= ovf_d;
    end
  end

  assign Zero = zero_q;
  assign Ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_alu4bit.sv
// tb_alu4bit: directed self-checking bench for alu4bit.
// Each step drives operands/opcode just after a rising edge, advances one
// edge and compares {CiOut,F3..F0} against a hand-computed value.
module tb_alu4bit;
  import alu4bit_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ci_out, f3, f2, f1, f0;
`ifdef ALU4BIT_FLAGS_EN
  logic zero, ovf;
`endif

  int n_checks = 0;
  int n_errors = 0;

  alu4bit_if bus ();

  alu4bit dut (
    .clk   (clk),
    .rst   (rst),
    .A     (bus.a),
    .B     (bus.b),
    .S0    (bus.op[0]),
    .S1    (bus.op[1]),
    .M     (bus.op[2]),
    .CiOut (ci_out),
    .F3    (f3),
    .F2    (f2),
    .F1    (f1),
    .F0    (f0)
`ifdef ALU4BIT_FLAGS_EN
    ,
    .Zero  (zero),
    .Ovf   (ovf)
`endif
  );

  // clock / reset timing
  always #5 clk = ~clk;

  // driver: present one operation, then advance to just after the next edge
  task automatic drive(input logic [3:0] a, input logic [3:0] b, input opcode_e op);
    bus.a  = a;
    bus.b  = b;
    bus.op = op;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // scoreboard compare of {CiOut,F3,F2,F1,F0}
  task automatic check(input string tag, input logic [4:0] exp);
    logic [4:0] obs;
    obs = {ci_out, f3, f2, f1, f0};
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

`ifdef ALU4BIT_FLAGS_EN
  // compare {Ovf,Zero}
  task automatic check_flags(input string tag, input logic [1:0] exp);
    logic [1:0] obs;
    obs = {ovf, zero};
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed ovf/zero %b expected %b", tag, obs, exp);
    end
  endtask
`endif

  initial begin
    // reset for two cycles with an operation that would give nonzero output
    drive(4'b0000, 4'b1111, OP_NOT);
    rst = 1'b1;
    step();
    check("reset_cyc1", 5'b0_0000);
    step();
    check("reset_cyc2", 5'b0_0000);
    rst = 1'b0;
    step();
    check("post_reset_not", 5'b0_1111);

    // sweep A=0101 B=0100
    drive(4'b0101, 4'b0100, OP_ADD); step(); check("s1_add", 5'b0_1001);
    drive(4'b0101, 4'b0100, OP_SUB); step(); check("s1_sub", 5'b1_0001);
    drive(4'b0101, 4'b0100, OP_INC); step(); check("s1_inc", 5'b0_0110);
    drive(4'b0101, 4'b0100, OP_DEC); step(); check("s1_dec", 5'b1_0100);
    drive(4'b0101, 4'b0100, OP_AND); step(); check("s1_and", 5'b0_0100);
    drive(4'b0101, 4'b0100, OP_OR);  step(); check("s1_or",  5'b0_0101);
    drive(4'b0101, 4'b0100, OP_XOR); step(); check("s1_xor", 5'b0_0001);
    drive(4'b0101, 4'b0100, OP_NOT); step(); check("s1_not", 5'b0_1010);

    // sweep A=1010 B=0101
    drive(4'b1010, 4'b0101, OP_ADD); step(); check("s2_add", 5'b0_1111);
    drive(4'b1010, 4'b0101, OP_SUB); step(); check("s2_sub", 5'b1_0101);
    drive(4'b1010, 4'b0101, OP_INC); step(); check("s2_inc", 5'b0_1011);
    drive(4'b1010, 4'b0101, OP_DEC); step(); check("s2_dec", 5'b1_1001);
    drive(4'b1010, 4'b0101, OP_AND); step(); check("s2_and", 5'b0_0000);
    drive(4'b1010, 4'b0101, OP_OR);  step(); check("s2_or",  5'b0_1111);
    drive(4'b1010, 4'b0101, OP_XOR); step(); check("s2_xor", 5'b0_1111);
    drive(4'b1010, 4'b0101, OP_NOT); step(); check("s2_not", 5'b0_0101);

    // wrap-around cases
    drive(4'b1111, 4'b0001, OP_ADD); step(); check("wrap_add", 5'b1_0000);
    drive(4'b1111, 4'b0000, OP_INC); step(); check("wrap_inc", 5'b1_0000);
    drive(4'b0000, 4'b0000, OP_DEC); step(); check("wrap_dec", 5'b0_1111);
    drive(4'b0011, 4'b0101, OP_SUB); step(); check("wrap_sub", 5'b0_1110);
    drive(4'b0110, 4'b0110, OP_SUB); step(); check("sub_equal", 5'b1_0000);

    // latency: new inputs must not show before the edge, and must after it
    drive(4'b1100, 4'b0011, OP_OR);
    #2;
    check("hold_before_edge", 5'b1_0000);
    step();
    check("lat_or", 5'b0_1111);
    drive(4'b1001, 4'b0011, OP_XOR);
    #2;
    check("hold_or", 5'b0_1111);
    step();
    check("lat_xor", 5'b0_1010);
    drive(4'b1000, 4'b1000, OP_ADD);
    step();
    check("lat_add_carry", 5'b1_0000);

    // reset overrides an operation presented in the same cycle
    drive(4'b1111, 4'b0001, OP_ADD);
    rst = 1'b1;
    step();
    check("reset_mid_op", 5'b0_0000);
    rst = 1'b0;
    step();
    check("after_reset_add", 5'b1_0000);

`ifdef ALU4BIT_FLAGS_EN
    drive(4'b0111, 4'b0001, OP_ADD); step();
    check("flag_add_val", 5'b0_1000);
    check_flags("flag_add_ovf", 2'b10);
    drive(4'b1010, 4'b0101, OP_AND); step();
    check_flags("flag_and_zero", 2'b01);
    drive(4'b1000, 4'b0001, OP_SUB); step();
    check("flag_sub_val", 5'b1_0111);
    check_flags("flag_sub_ovf", 2'b10);
    drive(4'b0111, 4'b0000, OP_INC); step();
    check_flags("flag_inc_ovf", 2'b10);
    drive(4'b1000, 4'b0000, OP_DEC); step();
    check_flags("flag_dec_ovf", 2'b10);
    drive(4'b0001, 4'b0000, OP_DEC); step();
    check_flags("flag_dec_zero", 2'b01);
    drive(4'b1111, 4'b1111, OP_NOT); step();
    check_flags("flag_not_zero", 2'b01);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
